// File: rtl/xbar_pkg.sv
// Shared definitions for the xbar family of element crossbars.
package xbar_pkg;

    localparam int MAX_PIPE_STAGES = 4;

    // Index width for n items, never narrower than one bit.
    function automatic int sel_width(input int n);
        if (n <= 2) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/xbar_pipe_stage.sv
// One elastic ready/valid register stage; accepts whenever empty or draining.
module xbar_pipe_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data_i,
    input  logic             in_val_i,
    output logic             in_rdy_o,
    output logic [WIDTH-1:0] out_data_o,
    output logic             out_val_o,
    input  logic             out_rdy_i
);

    logic             val_q;
    logic             val_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic             rdy_s;

    // Ready and next-state; empty slots keep stale data to avoid needless toggling.
    always_comb begin
        rdy_s  = ~val_q | out_rdy_i;
        val_d  = val_q;
        data_d = data_q;
        if (rdy_s) begin
            val_d = in_val_i;
            if (in_val_i) begin
                data_d = in_data_i;
            end else begin
                data_d = data_q;
            end
        end else begin
            val_d  = val_q;
            data_d = data_q;
        end
    end

    // Stage state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            val_q  <= 1'b0;
            data_q <= '0;
        end else begin
            val_q  <= val_d;
            data_q <= data_d;
        end
    end

    assign in_rdy_o   = rdy_s;
    assign out_data_o = data_q;
    assign out_val_o  = val_q;

endmodule

// File: rtl/xbar_pipe.sv
// Element crossbar with per-output select/enable, sticky range error and
// an optional chain of elastic output stages.
module xbar_pipe
    import xbar_pkg::*;
#(
    parameter  int ELEM_WIDTH  = 32,
    parameter  int NUM_IN      = 32,
    parameter  int NUM_OUT     = 32,
    parameter  int PIPE_STAGES = 1,
    localparam int SEL_W       = sel_width(NUM_IN),
    localparam int CNT_W       = sel_width(PIPE_STAGES + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_IN*ELEM_WIDTH-1:0]  data_in,
    input  logic [NUM_OUT*SEL_W-1:0]      sel,
    input  logic [NUM_OUT-1:0]            out_en,
    input  logic                          data_in_val,
    output logic                          data_in_rdy,
    output logic [NUM_OUT*ELEM_WIDTH-1:0] data_out,
    output logic                          data_out_val,
    input  logic                          data_out_rdy,
    output logic                          sel_err,
    input  logic                          sel_err_clr,
    output logic [CNT_W-1:0]              inflight
);

    localparam int               PAD_IN   = 2 ** SEL_W;
    localparam logic [SEL_W:0]   NUM_IN_L = (SEL_W + 1)'(NUM_IN);

    logic [ELEM_WIDTH-1:0]         in_pad_s [PAD_IN];
    logic [SEL_W-1:0]              sel_s    [NUM_OUT];
    logic [NUM_OUT*ELEM_WIDTH-1:0] mux_s;
    logic                          err_now_s;
    logic                          in_fire_s;
    logic                          sel_err_q;
    logic                          sel_err_d;

    if (PIPE_STAGES < 0 || PIPE_STAGES > MAX_PIPE_STAGES) begin : g_bad_stages
        $error("xbar_pipe: PIPE_STAGES out of range");
    end

    // Pad the input array to a power of two so any select value indexes safely.
    for (genvar i = 0; i < PAD_IN; i++) begin : g_pad
        if (i < NUM_IN) begin : g_real
            assign in_pad_s[i] = data_in[i*ELEM_WIDTH +: ELEM_WIDTH];
        end else begin : g_zero
            assign in_pad_s[i] = '0;
        end
    end

    for (genvar j = 0; j < NUM_OUT; j++) begin : g_sel
        assign sel_s[j] = sel[j*SEL_W +: SEL_W];
    end

    // Per-output mux; only enabled outputs can raise a range error.
    always_comb begin
        mux_s     = '0;
        err_now_s = 1'b0;
        for (int j = 0; j < NUM_OUT; j++) begin
            if (!out_en[j]) begin
                mux_s[j*ELEM_WIDTH +: ELEM_WIDTH] = '0;
            end else if ({1'b0, sel_s[j]} >= NUM_IN_L) begin
                mux_s[j*ELEM_WIDTH +: ELEM_WIDTH] = '0;
                err_now_s                         = 1'b1;
            end else begin
                mux_s[j*ELEM_WIDTH +: ELEM_WIDTH] = in_pad_s[sel_s[j]];
            end
        end
    end

    assign in_fire_s = data_in_val & data_in_rdy;

    // Sticky error: a newly accepted error beats a same-cycle clear.
    always_comb begin
        if (in_fire_s && err_now_s) begin
            sel_err_d = 1'b1;
        end else if (sel_err_clr) begin
            sel_err_d = 1'b0;
        end else begin
            sel_err_d = sel_err_q;
        end
    end

    // Error flag register.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_err_q <= 1'b0;
        end else begin
            sel_err_q <= sel_err_d;
        end
    end

    assign sel_err = sel_err_q;

    if (PIPE_STAGES == 0) begin : g_comb
        assign data_out     = mux_s;
        assign data_out_val = data_in_val;
        assign data_in_rdy  = data_out_rdy;
        assign inflight     = '0;
    end else begin : g_pipe
        logic [NUM_OUT*ELEM_WIDTH-1:0] stg_data_s [PIPE_STAGES+1];
        logic [PIPE_STAGES:0]          stg_val_s;
        logic [PIPE_STAGES:0]          stg_rdy_s;
        logic [CNT_W-1:0]              cnt_q;
        logic [CNT_W-1:0]              cnt_d;
        logic                          out_fire_s;

        assign stg_data_s[0]          = mux_s;
        assign stg_val_s[0]           = data_in_val;
        assign stg_rdy_s[PIPE_STAGES] = data_out_rdy;

        // Ready ripples combinationally back through the chain, so no bubbles.
        for (genvar k = 0; k < PIPE_STAGES; k++) begin : g_stage
            xbar_pipe_stage #(
                .WIDTH (NUM_OUT * ELEM_WIDTH)
            ) u_stage (
                .clk        (clk),
                .rst        (rst),
                .in_data_i  (stg_data_s[k]),
                .in_val_i   (stg_val_s[k]),
                .in_rdy_o   (stg_rdy_s[k]),
                .out_data_o (stg_data_s[k+1]),
                .out_val_o  (stg_val_s[k+1]),
                .out_rdy_i  (stg_rdy_s[k+1])
            );
        end

        assign data_in_rdy  = stg_rdy_s[0];
        assign data_out     = stg_data_s[PIPE_STAGES];
        assign data_out_val = stg_val_s[PIPE_STAGES];
        assign out_fire_s   = data_out_val & data_out_rdy;

        // Occupancy tracks accepts minus emits, equal to the count of valid stages.
        always_comb begin
            case ({in_fire_s, out_fire_s})
                2'b10:   cnt_d = cnt_q + CNT_W'(1);
                2'b01:   cnt_d = cnt_q - CNT_W'(1);
                default: cnt_d = cnt_q;
            endcase
        end

        // Occupancy register.
        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign inflight = cnt_q;
    end

endmodule

// File: tb/tb_xbar_pipe.sv
// Bench for xbar_pipe: three instances (2-stage 4x4, 3-stage 3x5, combinational 3x5).
module tb_xbar_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Instance A: 4 in, 4 out, 8-bit, 2 stages
    logic [31:0] a_din;
    logic [7:0]  a_sel;
    logic [3:0]  a_en;
    logic        a_val, a_irdy, a_oval, a_ordy, a_err, a_clr;
    logic [31:0] a_dout;
    logic [1:0]  a_infl;

    // Instance B: 3 in, 5 out, 8-bit, 3 stages
    logic [23:0] b_din;
    logic [9:0]  b_sel;
    logic [4:0]  b_en;
    logic        b_val, b_irdy, b_oval, b_ordy, b_err, b_clr;
    logic [39:0] b_dout;
    logic [1:0]  b_infl;

    // Instance C: 3 in, 5 out, 8-bit, combinational
    logic [23:0] c_din;
    logic [9:0]  c_sel;
    logic [4:0]  c_en;
    logic        c_val, c_irdy, c_oval, c_ordy, c_err, c_clr;
    logic [39:0] c_dout;
    logic [0:0]  c_infl;

    xbar_pipe #(.ELEM_WIDTH(8), .NUM_IN(4), .NUM_OUT(4), .PIPE_STAGES(2)) u_a (
        .clk(clk), .rst(rst), .data_in(a_din), .sel(a_sel), .out_en(a_en),
        .data_in_val(a_val), .data_in_rdy(a_irdy), .data_out(a_dout),
        .data_out_val(a_oval), .data_out_rdy(a_ordy), .sel_err(a_err),
        .sel_err_clr(a_clr), .inflight(a_infl));

    xbar_pipe #(.ELEM_WIDTH(8), .NUM_IN(3), .NUM_OUT(5), .PIPE_STAGES(3)) u_b (
        .clk(clk), .rst(rst), .data_in(b_din), .sel(b_sel), .out_en(b_en),
        .data_in_val(b_val), .data_in_rdy(b_irdy), .data_out(b_dout),
        .data_out_val(b_oval), .data_out_rdy(b_ordy), .sel_err(b_err),
        .sel_err_clr(b_clr), .inflight(b_infl));

    xbar_pipe #(.ELEM_WIDTH(8), .NUM_IN(3), .NUM_OUT(5), .PIPE_STAGES(0)) u_c (
        .clk(clk), .rst(rst), .data_in(c_din), .sel(c_sel), .out_en(c_en),
        .data_in_val(c_val), .data_in_rdy(c_irdy), .data_out(c_dout),
        .data_out_val(c_oval), .data_out_rdy(c_ordy), .sel_err(c_err),
        .sel_err_clr(c_clr), .inflight(c_infl));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference mux for the 3-in/5-out shape: {range error, routed elements}.
    function automatic logic [40:0] ref_route(input logic [23:0] din, input logic [9:0] s,
                                              input logic [4:0] en);
        logic [39:0] o;
        logic        e;
        int          idx;
        o = '0;
        e = 1'b0;
        for (int j = 0; j < 5; j++) begin
            idx = int'(s[2*j +: 2]);
            if (en[j]) begin
                if (idx >= 3) e = 1'b1;
                else o[8*j +: 8] = din[8*idx +: 8];
            end
        end
        return {e, o};
    endfunction

    // Scoreboard for instance B: queue of accepted beats with accept cycle.
    typedef struct {
        logic [39:0] d;
        int          t;
    } beat_t;
    beat_t q[$];
    int    cyc = 0;
    int    got = 0;
    logic  m_err = 1'b0;

    task automatic cycle_b(input logic [23:0] din, input logic [9:0] s, input logic [4:0] en,
                           input logic val, input logic ordy, input logic clr, output logic in_f);
        logic        exp_rdy, exp_val, out_f;
        logic [40:0] r;
        beat_t       nb;
        b_din = din; b_sel = s; b_en = en; b_val = val; b_ordy = ordy; b_clr = clr;
        #1;
        exp_rdy = !(q.size() == 3 && !ordy);
        exp_val = (q.size() > 0) && (cyc - q[0].t >= 3);
        chk("b_in_rdy", 64'(b_irdy), 64'(exp_rdy));
        chk("b_out_val", 64'(b_oval), 64'(exp_val));
        if (exp_val) chk("b_data", 64'(b_dout), 64'(q[0].d));
        chk("b_inflight", 64'(b_infl), 64'(q.size()));
        chk("b_sel_err", 64'(b_err), 64'(m_err));
        r     = ref_route(din, s, en);
        in_f  = val && exp_rdy;
        out_f = exp_val && ordy;
        @(posedge clk);
        if (out_f) begin
            void'(q.pop_front());
            got++;
        end
        if (in_f) begin
            nb.d = r[39:0];
            nb.t = cyc;
            q.push_back(nb);
        end
        if (in_f && r[40]) m_err = 1'b1;
        else if (clr) m_err = 1'b0;
        cyc++;
        #1;
    endtask

    task automatic drain_b();
        logic f;
        for (int k = 0; k < 20 && q.size() > 0; k++) begin
            cycle_b(24'h0, 10'h0, 5'h0, 1'b0, 1'b1, 1'b0, f);
        end
        chk("b_drained", 64'(q.size()), 64'd0);
    endtask

    typedef struct {
        logic [23:0] din;
        logic [9:0]  sel;
        logic [4:0]  en;
        logic        val;
        logic        ordy;
        logic [39:0] dout;
        logic        oval;
        logic        irdy;
    } vec_t;
    vec_t tbl[5];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic f;
        int   sent;
        int   got_base;
        logic saw_full;

        a_din = '0; a_sel = '0; a_en = '0; a_val = 1'b0; a_ordy = 1'b1; a_clr = 1'b0;
        b_din = '0; b_sel = '0; b_en = '0; b_val = 1'b0; b_ordy = 1'b1; b_clr = 1'b0;
        c_din = '0; c_sel = '0; c_en = '0; c_val = 1'b0; c_ordy = 1'b1; c_clr = 1'b0;

        rst = 1'b1;
        tick();
        tick();
        chk("a_rst_val", 64'(a_oval), 64'd0);
        chk("a_rst_data", 64'(a_dout), 64'd0);
        chk("a_rst_infl", 64'(a_infl), 64'd0);
        chk("a_rst_rdy", 64'(a_irdy), 64'd1);
        chk("b_rst_val", 64'(b_oval), 64'd0);
        chk("b_rst_err", 64'(b_err), 64'd0);
        chk("c_rst_err", 64'(c_err), 64'd0);
        rst = 1'b0;

        // Combinational instance: table of vectors, data in = {CC,BB,AA}
        tbl[0] = '{24'hCCBBAA, 10'b00_01_10_00_01, 5'b11111, 1'b1, 1'b1, 40'hAABBCCAABB, 1'b1, 1'b1};
        tbl[1] = '{24'hCCBBAA, 10'b00_01_10_00_01, 5'b01010, 1'b0, 1'b0, 40'h00BB00AA00, 1'b0, 1'b0};
        tbl[2] = '{24'hCCBBAA, 10'b11_11_11_11_11, 5'b00000, 1'b1, 1'b0, 40'h0000000000, 1'b1, 1'b0};
        tbl[3] = '{24'hAB0000, 10'b10_10_10_10_10, 5'b10101, 1'b0, 1'b1, 40'hAB00AB00AB, 1'b0, 1'b1};
        tbl[4] = '{24'hCCBBAA, 10'b11_10_01_00_11, 5'b11111, 1'b1, 1'b1, 40'h00CCBBAA00, 1'b1, 1'b1};
        for (int i = 0; i < 5; i++) begin
            c_din = tbl[i].din; c_sel = tbl[i].sel; c_en = tbl[i].en;
            c_val = tbl[i].val; c_ordy = tbl[i].ordy;
            #1;
            chk($sformatf("c_data[%0d]", i), 64'(c_dout), 64'(tbl[i].dout));
            chk($sformatf("c_val[%0d]", i), 64'(c_oval), 64'(tbl[i].oval));
            chk($sformatf("c_rdy[%0d]", i), 64'(c_irdy), 64'(tbl[i].irdy));
            chk($sformatf("c_err[%0d]", i), 64'(c_err), 64'd0);
            chk($sformatf("c_infl[%0d]", i), 64'(c_infl), 64'd0);
            tick();
        end
        chk("c_err_set", 64'(c_err), 64'd1);
        c_val = 1'b0; c_clr = 1'b1;
        tick();
        c_clr = 1'b0;
        chk("c_err_clr", 64'(c_err), 64'd0);

        // Instance A: reversing route, 2-cycle latency
        a_din = 32'h44332211; a_sel = 8'b00_01_10_11; a_en = 4'hF; a_val = 1'b1; a_ordy = 1'b1;
        #1;
        chk("a_id_rdy", 64'(a_irdy), 64'd1);
        tick();
        a_val = 1'b0;
        chk("a_id_lat1", 64'(a_oval), 64'd0);
        chk("a_id_infl1", 64'(a_infl), 64'd1);
        tick();
        chk("a_id_val", 64'(a_oval), 64'd1);
        chk("a_id_data", 64'(a_dout), 64'h11223344);
        tick();
        chk("a_id_done", 64'(a_oval), 64'd0);
        chk("a_id_infl0", 64'(a_infl), 64'd0);

        // Instance A: fill under stall, then reset mid-stream
        a_ordy = 1'b0; a_val = 1'b1; a_din = 32'h01020304;
        tick();
        tick();
        a_val = 1'b0;
        chk("a_full_infl", 64'(a_infl), 64'd2);
        chk("a_full_val", 64'(a_oval), 64'd1);
        chk("a_full_rdy", 64'(a_irdy), 64'd0);
        rst = 1'b1;
        tick();
        chk("a_mrst_val", 64'(a_oval), 64'd0);
        chk("a_mrst_infl", 64'(a_infl), 64'd0);
        chk("a_mrst_err", 64'(a_err), 64'd0);
        chk("a_mrst_data", 64'(a_dout), 64'd0);
        chk("a_mrst_rdy", 64'(a_irdy), 64'd1);
        rst = 1'b0; a_ordy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("a_no_stale", 64'(a_oval), 64'd0);
        end

        // Instance B: broadcast with mask
        cycle_b(24'hAB0000, 10'b10_10_10_10_10, 5'b10101, 1'b1, 1'b1, 1'b0, f);
        cycle_b(24'h0, 10'h0, 5'h0, 1'b0, 1'b1, 1'b0, f);
        cycle_b(24'h0, 10'h0, 5'h0, 1'b0, 1'b1, 1'b0, f);
        chk("b_bcast_val", 64'(b_oval), 64'd1);
        chk("b_bcast_data", 64'(b_dout), 64'hAB00AB00AB);
        drain_b();

        // Instance B: out-of-range select, clear, then masked out-of-range
        cycle_b(24'h030201, 10'b00_00_00_00_11, 5'b00001, 1'b1, 1'b1, 1'b0, f);
        chk("b_oor_set", 64'(b_err), 64'd1);
        cycle_b(24'h0, 10'h0, 5'h0, 1'b0, 1'b1, 1'b1, f);
        chk("b_oor_clr", 64'(b_err), 64'd0);
        cycle_b(24'h030201, 10'b00_00_00_00_11, 5'b00010, 1'b1, 1'b1, 1'b0, f);
        chk("b_oor_masked", 64'(b_err), 64'd0);
        drain_b();

        // Instance B: backpressure on 10 incrementing beats
        sent = 0; got_base = got; saw_full = 1'b0;
        for (int k = 0; k < 40 && (got - got_base) < 10; k++) begin
            cycle_b({3{8'(sent + 1)}}, 10'h0, 5'h1F, (sent < 10), !(k >= 4 && k <= 8), 1'b0, f);
            if (f) sent++;
            if (b_infl == 2'd3) saw_full = 1'b1;
        end
        chk("b_bp_count", 64'(got - got_base), 64'd10);
        chk("b_bp_full", 64'(saw_full), 64'd1);

        // Instance B: random traffic against the scoreboard
        for (int k = 0; k < 300; k++) begin
            cycle_b(24'($urandom), 10'($urandom), 5'($urandom), ($urandom_range(0, 9) < 7),
                    ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) == 0), f);
        end
        drain_b();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
